// File: rtl/stat_arb_engine.sv
// Pairs-trading engine: rolling mean of the price spread, deviation thresholds, position FSM.
// Optional STAT_ARB_COOLDOWN_EN: after an exit, entries are ignored for COOLDOWN accepted samples.
//
// state | meaning
// FLAT  | no position, evaluating entries
// LONG  | long stock1 / short stock2, waiting for exit
// SHORT | long stock2 / short stock1, waiting for exit
// COOL  | post-exit cooldown (only with STAT_ARB_COOLDOWN_EN)
module stat_arb_engine #(
    parameter int W        = 16,
    parameter int AVG_LOG2 = 3,
    parameter int ENTRY_TH = 100,
    parameter int EXIT_TH  = 20,
    parameter int COOLDOWN = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   stock1_price,
    input  logic [W-1:0]   stock2_price,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W:0]     spread,
    output logic [W:0]     mean,
    output logic [W+1:0]   deviation,
    output logic           buy_signal,
    output logic           sell_signal,
    output logic           exit_signal,
    output logic [1:0]     position,
    output logic           warm
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = W + 1 + AVG_LOG2;
    localparam logic [AVG_LOG2:0]  CNT_N = (AVG_LOG2 + 1)'(N);
    localparam logic signed [W+1:0] ENT  = (W + 2)'(ENTRY_TH);
    localparam logic signed [W+1:0] EXT  = (W + 2)'(EXIT_TH);
    // A misconfigured threshold set never opens a position.
    localparam bit CFG_OK = (ENTRY_TH >= 0) && (EXIT_TH >= 0) &&
                            (EXIT_TH < ENTRY_TH) && (COOLDOWN >= 0);

    typedef enum logic [1:0] {
        FLAT  = 2'd0,
        LONG  = 2'd1,
        SHORT = 2'd2,
        COOL  = 2'd3
    } pos_t;

    logic                  accept;
    logic signed [W:0]     spread_c;
    logic signed [W:0]     mean_c;
    logic signed [W:0]     oldest;
    logic signed [W+1:0]   dev_c;
    logic signed [SW-1:0]  sum_q;
    logic signed [SW-1:0]  sum_new;
    logic signed [W:0]     buf_q [N];
    logic [AVG_LOG2-1:0]   ptr_q;
    logic [AVG_LOG2:0]     cnt_q;
    logic [AVG_LOG2:0]     cnt_next;
    logic                  warm_c;
    pos_t                  state_q;
    pos_t                  state_d;
    logic                  buy_d;
    logic                  sell_d;
    logic                  exit_d;
    logic                  enter_long;
    logic                  enter_short;
    logic                  eval_flat;

`ifdef STAT_ARB_COOLDOWN_EN
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
    localparam pos_t EXIT_TO = COOL;
    logic [CW-1:0] cool_q;
    logic [CW-1:0] cool_d;
`else
    localparam pos_t EXIT_TO = FLAT;
`endif

    assign in_ready = out_ready || !out_valid;
    assign accept   = in_valid && in_ready;
    assign position = state_q;

    // Zero-extended operands keep the difference exact at W+1 bits.
    assign spread_c = $signed({1'b0, stock1_price}) - $signed({1'b0, stock2_price});
    assign oldest   = buf_q[ptr_q];
    assign sum_new  = sum_q - SW'(oldest) + SW'(spread_c);
    assign mean_c   = (W + 1)'(sum_new >>> AVG_LOG2);
    assign dev_c    = (W + 2)'(spread_c) - (W + 2)'(mean_c);
    assign cnt_next = (cnt_q == CNT_N) ? cnt_q : cnt_q + 1'b1;
    assign warm_c   = (cnt_next == CNT_N);

    assign enter_long  = CFG_OK && (dev_c > ENT);
    assign enter_short = CFG_OK && (dev_c < -ENT);

    // An expired cooldown evaluates the sample exactly as FLAT would.
`ifdef STAT_ARB_COOLDOWN_EN
    assign eval_flat = (state_q == FLAT) || ((state_q == COOL) && (cool_q == '0));
`else
    assign eval_flat = (state_q == FLAT) || (state_q == COOL);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FLAT;
`ifdef STAT_ARB_COOLDOWN_EN
            cool_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef STAT_ARB_COOLDOWN_EN
            cool_q  <= cool_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        buy_d   = 1'b0;
        sell_d  = 1'b0;
        exit_d  = 1'b0;
`ifdef STAT_ARB_COOLDOWN_EN
        cool_d  = cool_q;
`endif
        if (accept) begin
            if (!warm_c) begin
                state_d = FLAT;
            end else if (eval_flat) begin
                state_d = FLAT;
                if (enter_long) begin
                    state_d = LONG;
                    buy_d   = 1'b1;
                end else if (enter_short) begin
                    state_d = SHORT;
                    sell_d  = 1'b1;
                end
            end else begin
                case (state_q)
                    LONG: begin
                        if (dev_c <= EXT) begin
                            state_d = EXIT_TO;
                            exit_d  = 1'b1;
`ifdef STAT_ARB_COOLDOWN_EN
                            cool_d  = CW'(COOLDOWN);
`endif
                        end
                    end
                    SHORT: begin
                        if (dev_c >= -EXT) begin
                            state_d = EXIT_TO;
                            exit_d  = 1'b1;
`ifdef STAT_ARB_COOLDOWN_EN
                            cool_d  = CW'(COOLDOWN);
`endif
                        end
                    end
                    default: begin
`ifdef STAT_ARB_COOLDOWN_EN
                        cool_d  = cool_q - 1'b1;
`else
                        state_d = FLAT;
`endif
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            spread      <= '0;
            mean        <= '0;
            deviation   <= '0;
            buy_signal  <= 1'b0;
            sell_signal <= 1'b0;
            exit_signal <= 1'b0;
            warm        <= 1'b0;
            sum_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else if (accept) begin
            out_valid    <= 1'b1;
            spread       <= spread_c;
            mean         <= mean_c;
            deviation    <= dev_c;
            buy_signal   <= buy_d;
            sell_signal  <= sell_d;
            exit_signal  <= exit_d;
            warm         <= warm_c;
            sum_q        <= sum_new;
            buf_q[ptr_q] <= spread_c;
            ptr_q        <= ptr_q + 1'b1;
            cnt_q        <= cnt_next;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
            buy_signal  <= 1'b0;
            sell_signal <= 1'b0;
            exit_signal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stat_arb_engine.sv
// Directed bench for stat_arb_engine (W=16, window 4, thresholds 100/20, cooldown 3).
// Expected positions follow STAT_ARB_COOLDOWN_EN when it is defined for the build.
module tb_stat_arb_engine;

`ifdef STAT_ARB_COOLDOWN_EN
    localparam bit CD = 1'b1;
`else
    localparam bit CD = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic [15:0]        s1 = '0;
    logic [15:0]        s2 = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [16:0] spread;
    logic signed [16:0] mean;
    logic signed [17:0] deviation;
    logic               buy_signal;
    logic               sell_signal;
    logic               exit_signal;
    logic [1:0]         position;
    logic               warm;

    always #5 clk = ~clk;

    stat_arb_engine #(
        .W(16), .AVG_LOG2(2), .ENTRY_TH(100), .EXIT_TH(20), .COOLDOWN(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .stock1_price(s1), .stock2_price(s2), .out_valid(out_valid), .out_ready(out_ready),
        .spread(spread), .mean(mean), .deviation(deviation),
        .buy_signal(buy_signal), .sell_signal(sell_signal), .exit_signal(exit_signal),
        .position(position), .warm(warm)
    );

    typedef struct {
        bit rst;
        int a;
        int b;
        int sp;
        int mn;
        int dv;
        bit buy;
        bit sell;
        bit ex;
        int pos;
        bit wrm;
    } vec_t;

    vec_t vecs[25];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_position", position, 0);
        check("rst_warm", warm, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic send(input int a, input int b);
        int k;
        @(negedge clk);
        s1 = a[15:0];
        s2 = b[15:0];
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst a     b     sp    mn   dv    buy  sell ex  pos                 warm
        vecs[0]  = '{1, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  0};
        vecs[1]  = '{0, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  0};
        vecs[2]  = '{0, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  0};
        vecs[3]  = '{0, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  1};
        vecs[4]  = '{0, 1200, 1000, 200,  50,  150,  1,   0,   0,  1,                  1};
        vecs[5]  = '{0, 1000, 1000, 0,    50,  -50,  0,   0,   1,  CD ? 3 : 0,         1};
        vecs[6]  = '{0, 1400, 1000, 400,  150, 250,  !CD, 0,   0,  CD ? 3 : 1,         1};
        vecs[7]  = '{0, 1400, 1000, 400,  250, 150,  0,   0,   0,  CD ? 3 : 1,         1};
        vecs[8]  = '{0, 1800, 1000, 800,  400, 400,  0,   0,   0,  CD ? 3 : 1,         1};
        vecs[9]  = '{0, 2600, 1000, 1600, 800, 800,  CD,  0,   0,  1,                  1};
        vecs[10] = '{1, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  0};
        vecs[11] = '{0, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  0};
        vecs[12] = '{0, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  0};
        vecs[13] = '{0, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  1};
        vecs[14] = '{0, 1000, 1200, -200, -50, -150, 0,   1,   0,  2,                  1};
        vecs[15] = '{0, 1000, 1000, 0,    -50, 50,   0,   0,   1,  CD ? 3 : 0,         1};
        vecs[16] = '{0, 1000, 1001, -1,   -51, 50,   0,   0,   0,  CD ? 3 : 0,         1};
        vecs[17] = '{1, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  0};
        vecs[18] = '{0, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  0};
        vecs[19] = '{0, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  0};
        vecs[20] = '{0, 1000, 1000, 0,    0,   0,    0,   0,   0,  0,                  1};
        vecs[21] = '{0, 1133, 1000, 133,  33,  100,  0,   0,   0,  0,                  1};
        vecs[22] = '{0, 1000, 1089, -89,  11,  -100, 0,   0,   0,  0,                  1};
        vecs[23] = '{0, 1300, 1000, 300,  86,  214,  1,   0,   0,  1,                  1};
        vecs[24] = '{0, 1141, 1000, 141,  121, 20,   0,   0,   1,  CD ? 3 : 0,         1};

        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (vecs[i].rst) do_reset();
            send(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_out_valid", i), out_valid, 1);
            check($sformatf("v%0d_spread", i), spread, vecs[i].sp);
            check($sformatf("v%0d_mean", i), mean, vecs[i].mn);
            check($sformatf("v%0d_deviation", i), deviation, vecs[i].dv);
            check($sformatf("v%0d_buy", i), buy_signal, int'(vecs[i].buy));
            check($sformatf("v%0d_sell", i), sell_signal, int'(vecs[i].sell));
            check($sformatf("v%0d_exit", i), exit_signal, int'(vecs[i].ex));
            check($sformatf("v%0d_position", i), position, vecs[i].pos);
            check($sformatf("v%0d_warm", i), warm, int'(vecs[i].wrm));
        end

        // Transfer with no new acceptance drops out_valid.
        repeat (2) @(negedge clk);
        check("drain_out_valid", out_valid, 0);
        check("drain_exit", exit_signal, 0);

        // Backpressure: result A held for 5 cycles, B waits, then transfers in.
        @(negedge clk);
        out_ready = 1'b0;
        s1 = 16'd1000;
        s2 = 16'd1010;
        in_valid = 1'b1;
        #1;
        check("bp_in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        check("bp_a_out_valid", out_valid, 1);
        check("bp_a_spread", spread, -10);
        check("bp_a_mean", mean, 85);
        check("bp_a_deviation", deviation, -95);
        s1 = 16'd1005;
        s2 = 16'd1000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_in_ready", c), in_ready, 0);
            check($sformatf("bp_hold%0d_out_valid", c), out_valid, 1);
            check($sformatf("bp_hold%0d_spread", c), spread, -10);
            check($sformatf("bp_hold%0d_deviation", c), deviation, -95);
            check($sformatf("bp_hold%0d_position", c), position, CD ? 3 : 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_b_out_valid", out_valid, 1);
        check("bp_b_spread", spread, 5);
        check("bp_b_mean", mean, 109);
        check("bp_b_deviation", deviation, -104);
        check("bp_b_sell", sell_signal, CD ? 0 : 1);
        check("bp_b_position", position, CD ? 3 : 2);

        // Reset while a result is in flight discards it and restarts warm-up.
        @(negedge clk);
        out_ready = 1'b0;
        s1 = 16'd1200;
        s2 = 16'd1000;
        in_valid = 1'b1;
        #2;
        check("mid_pre_out_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_spread", spread, 0);
        check("mid_rst_position", position, 0);
        check("mid_rst_warm", warm, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        send(1200, 1000);
        check("mid_post_spread", spread, 200);
        check("mid_post_mean", mean, 50);
        check("mid_post_deviation", deviation, 150);
        check("mid_post_buy", buy_signal, 0);
        check("mid_post_position", position, 0);
        check("mid_post_warm", warm, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
